// File: rtl/wddl_phase_ctrl.sv
// Precharge/evaluate sequencer for a WDDL dual-rail island: drives spacer then
// complementary rails, samples the network result and checks the rail code.
module wddl_phase_ctrl #(
  parameter int W        = 8,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] net_t,
  output logic [W-1:0] net_f,
  input  logic [W-1:0] res_t,
  input  logic [W-1:0] res_f,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err,
  output logic         err_spacer,
  output logic         err_code
);

  localparam int MAX_CYC = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {IDLE, PRECH, EVAL, OUT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [W-1:0]     op_p0;
  logic             accept, pre_end, eval_end;

  // Any asserted rail at the end of precharge means the island did not return to spacer.
  function automatic logic spacer_bad(input logic [W-1:0] t, input logic [W-1:0] f);
    return |(t | f);
  endfunction

  function automatic logic code_bad(input logic [W-1:0] t, input logic [W-1:0] f);
    return (t ^ f) != {W{1'b1}};
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    pre_end   = 1'b0;
    eval_end  = 1'b0;
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == OUT);
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = PRECH;
          cnt_nxt   = CNT_W'(PRE_CYC - 1);
        end
      end
      PRECH: begin
        if (cnt == '0) begin
          pre_end   = 1'b1;
          state_nxt = EVAL;
          cnt_nxt   = CNT_W'(EVAL_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      EVAL: begin
        if (cnt == '0) begin
          eval_end  = 1'b1;
          state_nxt = OUT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) op_p0 <= in_data;
  end

  // Rails are registered from the next state so they only carry a codeword while in EVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      net_t      <= '0;
      net_f      <= '0;
      out_data   <= '0;
      out_err    <= 1'b0;
      err_spacer <= 1'b0;
      err_code   <= 1'b0;
    end else begin
      net_t <= (state_nxt == EVAL) ? op_p0  : '0;
      net_f <= (state_nxt == EVAL) ? ~op_p0 : '0;
      if (accept) out_err <= 1'b0;
      if (pre_end && spacer_bad(res_t, res_f)) err_spacer <= 1'b1;
      if (eval_end) begin
        out_data <= res_t;
        out_err  <= code_bad(res_t, res_f);
        if (code_bad(res_t, res_f)) err_code <= 1'b1;
      end
    end
  end

endmodule
